// File: rtl/apb_completer_regfile.sv
// APB3 completer with a small word-addressed register file, read-only ID word,
// programmable wait states, address-error decode and a sticky protocol-violation flag.
module apb_completer_regfile #(
  parameter int unsigned NUM_REGS    = 16,
  parameter int unsigned WAIT_CYCLES = 0,
  parameter logic [31:0] ID_VALUE    = 32'hA5B0_0001
) (
  input  logic        pclk,
  input  logic        preset,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [7:0]  paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr,
  output logic        proto_err,
  input  logic        proto_err_clr
);

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 4;
  localparam int unsigned IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [AW-1:0]   lat_addr, lat_addr_n;
  logic            lat_write, lat_write_n;
  logic [DW-1:0]   lat_wdata, lat_wdata_n;
  logic            lat_err, lat_err_n;
  logic            wr_en, proto_set, setup_err;
  logic [DW-1:0]   regs [NUM_REGS];
  logic [IW-1:0]   lat_idx;
  logic [DW-1:0]   rd_word;

  // Address decode for the transfer being set up
  assign setup_err = (paddr[1:0] != 2'b00)
                  || (7'(paddr[7:2]) >= 7'(NUM_REGS))
                  || (pwrite && (paddr[7:2] == 6'd0));

  assign lat_idx = lat_addr[2 +: IW];
  assign rd_word = (lat_addr[7:2] == 6'd0) ? ID_VALUE : regs[lat_idx];

  assign pready  = (state == ACCESS) && (cnt == CW'(0)) && psel && penable;
  assign pslverr = pready && lat_err;
  assign prdata  = (pready && !lat_write && !lat_err) ? rd_word : DW'(0);

  always_ff @(posedge pclk) begin
    if (preset) begin
      state     <= IDLE;
      cnt       <= CW'(0);
      lat_addr  <= AW'(0);
      lat_write <= 1'b0;
      lat_wdata <= DW'(0);
      lat_err   <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      lat_addr  <= lat_addr_n;
      lat_write <= lat_write_n;
      lat_wdata <= lat_wdata_n;
      lat_err   <= lat_err_n;
    end
  end

  // Next-state logic; a stall cycle that breaks the handshake aborts the transfer
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    lat_addr_n  = lat_addr;
    lat_write_n = lat_write;
    lat_wdata_n = lat_wdata;
    lat_err_n   = lat_err;
    wr_en       = 1'b0;
    proto_set   = 1'b0;
    unique case (state)
      IDLE: begin
        if (psel && !penable) begin
          state_n     = ACCESS;
          cnt_n       = CW'(WAIT_CYCLES);
          lat_addr_n  = paddr;
          lat_write_n = pwrite;
          lat_wdata_n = pwdata;
          lat_err_n   = setup_err;
        end else if (penable) begin
          proto_set = 1'b1;
        end
      end
      ACCESS: begin
        if (pready) begin
          wr_en   = lat_write && !lat_err;
          state_n = IDLE;
        end else if (!psel || !penable || (paddr != lat_addr)
                     || (pwrite != lat_write) || (pwdata != lat_wdata)) begin
          proto_set = 1'b1;
          if (psel && !penable) begin
            state_n     = ACCESS;
            cnt_n       = CW'(WAIT_CYCLES);
            lat_addr_n  = paddr;
            lat_write_n = pwrite;
            lat_wdata_n = pwdata;
            lat_err_n   = setup_err;
          end else begin
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      for (int i = 0; i < int'(NUM_REGS); i++) regs[i] <= DW'(0);
    end else if (wr_en) begin
      regs[lat_idx] <= lat_wdata;
    end
  end

  // Sticky violation flag; a new violation wins over a simultaneous clear
  always_ff @(posedge pclk) begin
    if (preset)             proto_err <= 1'b0;
    else if (proto_set)     proto_err <= 1'b1;
    else if (proto_err_clr) proto_err <= 1'b0;
  end

endmodule

// File: tb/tb_apb_completer_regfile.sv
// Scoreboard bench: three completers (0, 3 and 2 wait states) on one shared bus,
// each with its own psel/penable; a monitor checks every completed transfer.
module tb_apb_completer_regfile;

  typedef struct packed {
    logic [31:0] rd;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        preset;
  logic [2:0]  psel_v, en_v, pready_v, pslverr_v, proto_v;
  logic        pwrite, clr;
  logic [7:0]  paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata_a [3];

  exp_t exp_q [$];
  int   checks = 0;
  int   errors = 0;
  int   cur    = 0;
  int   xfer_n = 0;

  always #5 clk = ~clk;

  apb_completer_regfile #(.NUM_REGS(16), .WAIT_CYCLES(0)) d0 (
    .pclk(clk), .preset(preset), .psel(psel_v[0]), .penable(en_v[0]), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata_a[0]), .pready(pready_v[0]),
    .pslverr(pslverr_v[0]), .proto_err(proto_v[0]), .proto_err_clr(clr));
  apb_completer_regfile #(.NUM_REGS(16), .WAIT_CYCLES(3)) d1 (
    .pclk(clk), .preset(preset), .psel(psel_v[1]), .penable(en_v[1]), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata_a[1]), .pready(pready_v[1]),
    .pslverr(pslverr_v[1]), .proto_err(proto_v[1]), .proto_err_clr(clr));
  apb_completer_regfile #(.NUM_REGS(16), .WAIT_CYCLES(2)) d2 (
    .pclk(clk), .preset(preset), .psel(psel_v[2]), .penable(en_v[2]), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata_a[2]), .pready(pready_v[2]),
    .pslverr(pslverr_v[2]), .proto_err(proto_v[2]), .proto_err_clr(clr));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: pops one expectation per completing cycle of the selected completer
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (pready_v[cur] === 1'b1) begin
        xfer_n++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_xfer%0d actual=pready required=no_transfer", xfer_n);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk($sformatf("xfer%0d_prdata", xfer_n), prdata_a[cur], e.rd);
          chk($sformatf("xfer%0d_pslverr", xfer_n), 32'(pslverr_v[cur]), 32'(e.err));
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after the completing edge
  task automatic xfer(input int d, input logic wr, input logic [7:0] a, input logic [31:0] wd,
                      input logic [31:0] erd, input logic eerr, input int ewait);
    int w;
    bit done;
    exp_t e;
    e.rd  = erd;
    e.err = eerr;
    exp_q.push_back(e);
    cur    = d;
    psel_v = 3'b000;
    en_v   = 3'b000;
    psel_v[d] = 1'b1;
    pwrite = wr;
    paddr  = a;
    pwdata = wd;
    @(negedge clk);
    en_v[d] = 1'b1;
    w = 0;
    done = 1'b0;
    while (!done && w < 50) begin
      #1;
      if (pready_v[d] === 1'b1) done = 1'b1;
      else begin
        w++;
        @(negedge clk);
      end
    end
    chk($sformatf("waits_d%0d_a%h", d, a), done ? 32'(w) : 32'hFFFF_FFFF, 32'(ewait));
    @(negedge clk);
  endtask

  task automatic bus_idle();
    psel_v = 3'b000;
    en_v   = 3'b000;
  endtask

  initial begin
    preset = 1'b1;
    psel_v = 3'b000;
    en_v   = 3'b000;
    pwrite = 1'b0;
    paddr  = 8'h00;
    pwdata = 32'h0;
    clr    = 1'b0;
    repeat (3) @(negedge clk);
    preset = 1'b0;
    #1;
    chk("rst_pready", 32'(pready_v), 32'h0);
    chk("rst_pslverr", 32'(pslverr_v), 32'h0);
    chk("rst_proto_err", 32'(proto_v), 32'h0);
    chk("rst_prdata", prdata_a[0] | prdata_a[1] | prdata_a[2], 32'h0);
    @(negedge clk);

    // Zero wait states, back-to-back, then error cases
    xfer(0, 1'b0, 8'h00, 32'h0,         32'hA5B0_0001, 1'b0, 0);
    xfer(0, 1'b1, 8'h04, 32'hDEAD_BEEF, 32'h0,         1'b0, 0);
    xfer(0, 1'b0, 8'h04, 32'h0,         32'hDEAD_BEEF, 1'b0, 0);
    xfer(0, 1'b1, 8'h0C, 32'h3333_3333, 32'h0,         1'b0, 0);
    xfer(0, 1'b1, 8'h00, 32'hFFFF_FFFF, 32'h0,         1'b1, 0);
    xfer(0, 1'b0, 8'h00, 32'h0,         32'hA5B0_0001, 1'b0, 0);
    xfer(0, 1'b0, 8'h40, 32'h0,         32'h0,         1'b1, 0);
    xfer(0, 1'b1, 8'h0D, 32'h5555_5555, 32'h0,         1'b1, 0);
    xfer(0, 1'b0, 8'h0C, 32'h0,         32'h3333_3333, 1'b0, 0);
    bus_idle();
    @(negedge clk);

    // Three wait states
    xfer(1, 1'b1, 8'h08, 32'h1234_5678, 32'h0,         1'b0, 3);
    xfer(1, 1'b0, 8'h08, 32'h0,         32'h1234_5678, 1'b0, 3);
    bus_idle();
    @(negedge clk);

    // Address change mid-ACCESS with two wait states
    xfer(2, 1'b1, 8'h04, 32'h1111_1111, 32'h0, 1'b0, 2);
    xfer(2, 1'b1, 8'h08, 32'h2222_2222, 32'h0, 1'b0, 2);
    cur = 2;
    psel_v = 3'b100;
    en_v   = 3'b000;
    pwrite = 1'b1;
    paddr  = 8'h04;
    pwdata = 32'hBAD0_BAD0;
    @(negedge clk);
    en_v = 3'b100;
    @(negedge clk);
    paddr = 8'h08;
    @(negedge clk);
    bus_idle();
    #1;
    chk("viol_proto_err", 32'(proto_v[2]), 32'h1);
    @(negedge clk);
    xfer(2, 1'b0, 8'h04, 32'h0, 32'h1111_1111, 1'b0, 2);
    xfer(2, 1'b0, 8'h08, 32'h0, 32'h2222_2222, 1'b0, 2);
    bus_idle();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    #1;
    chk("clr_proto_err", 32'(proto_v[2]), 32'h0);
    @(negedge clk);
    en_v = 3'b100;
    @(negedge clk);
    en_v = 3'b000;
    #1;
    chk("idle_penable_proto_err", 32'(proto_v[2]), 32'h1);
    chk("other_proto_err", 32'(proto_v[1:0]), 32'h0);
    @(negedge clk);

    // Reset in the middle of a write's ACCESS phase
    cur = 1;
    psel_v = 3'b010;
    en_v   = 3'b000;
    pwrite = 1'b1;
    paddr  = 8'h10;
    pwdata = 32'hCAFE_0000;
    @(negedge clk);
    en_v = 3'b010;
    #1;
    chk("rst_mid_pre_pready", 32'(pready_v[1]), 32'h0);
    @(negedge clk);
    preset = 1'b1;
    @(negedge clk);
    preset = 1'b0;
    bus_idle();
    #1;
    chk("rst_mid_pready", 32'(pready_v[1]), 32'h0);
    chk("rst_mid_proto_err", 32'(proto_v), 32'h0);
    @(negedge clk);
    xfer(1, 1'b0, 8'h10, 32'h0, 32'h0, 1'b0, 3);
    bus_idle();
    repeat (3) @(negedge clk);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
